cordic_fx2fp: RTL and testbench

CORDIC_FX2FP -- requirements
Module: cordic_fx2fp

---
 rtl/cordic_pkg.sv | 23 ++
 rtl/fp16_round_pack.sv | 39 +++
 rtl/cordic_fx2fp.sv | 96 +++++++++
 tb/tb_cordic_fx2fp.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC fixed-point to binary16 converter.
package cordic_pkg;

  localparam int unsigned FX_W     = 17;  // CORDIC result width, [12:-4]
  localparam int unsigned MAG_W    = 18;  // magnitude width, [13:-4]
  localparam int unsigned EXP_IN_W = 6;   // signed exponent input width
  localparam int unsigned EXP_W    = 8;   // internal signed exponent width
  localparam int unsigned FP_W     = 16;  // binary16 width

  localparam int unsigned FP16_BIAS    = 15;
  localparam int unsigned FP16_EXP_INF = 31;

  // Two's-complement CORDIC datapath value; bit 10 weighs 1.0
  typedef logic [12:-4] cordic_fx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } fx2fp_state_t;

endpackage

// File: rtl/fp16_round_pack.sv
// Round-to-nearest-even of a normalised magnitude and packing into binary16.
module fp16_round_pack
  import cordic_pkg::*;
(
  input  logic              sign,
  input  logic              mag_zero,
  input  logic [10:-4]      mag,
  input  logic signed [7:0] exp,
  input  logic              sticky,
  output logic [15:0]       fp_c
);

  logic              sticky_all;
  logic              inc;
  logic              carry;
  logic [9:0]        mant;
  logic signed [7:0] exp_r;
  logic signed [8:0] e;

  // Round at mag[0], then bias the exponent and saturate/flush out of range.
  always_comb begin
    sticky_all = sticky | (|mag[-2:-4]);
    inc        = mag[-1] & (sticky_all | mag[0]);
    // All-ones significand plus one wraps the fraction to zero and bumps exp
    carry      = inc & (&mag[10:0]);
    mant       = 10'(mag[9:0] + 10'(inc));
    exp_r      = exp + $signed({7'd0, carry});
    e          = $signed({exp_r[7], exp_r}) + $signed(9'(FP16_BIAS));
    fp_c       = {sign, e[4:0], mant};
    if (mag_zero) begin
      fp_c = {sign, 15'h0000};
    end else if (e >= $signed(9'(FP16_EXP_INF))) begin
      fp_c = {sign, 5'h1F, 10'h000};
    end else if (e <= 9'sd0) begin
      fp_c = {sign, 15'h0000};
    end
  end

endmodule

// File: rtl/cordic_fx2fp.sv
// Converts a CORDIC fixed-point result plus exponent to IEEE binary16.
module cordic_fx2fp
  import cordic_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  cordic_fx_t       fx_in,
  input  logic [5:0]       exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      fp_out
);

  fx2fp_state_t      state;
  logic              sign;
  logic [13:-4]      mag;
  logic signed [7:0] exp;
  logic              sticky;

  logic [17:0]       fx_ext;
  logic [17:0]       fx_abs;
  logic              mag_zero;
  logic [15:0]       fp_c;

  // Sign-extend and take the magnitude; 18 bits keep |-2^16| representable.
  always_comb begin
    fx_ext   = {fx_in[12], fx_in};
    fx_abs   = fx_in[12] ? 18'(~fx_ext + 18'd1) : fx_ext;
    mag_zero = (mag == '0);
  end

  assign in_ready = (state == IDLE);

  fp16_round_pack u_round_pack (
    .sign     (sign),
    .mag_zero (mag_zero),
    .mag      (mag[10:-4]),
    .exp      (exp),
    .sticky   (sticky),
    .fp_c     (fp_c)
  );

  // Handshake FSM with one normalising shift per NORM cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      fp_out    <= '0;
      mag       <= '0;
      exp       <= '0;
      sign      <= 1'b0;
      sticky    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign   <= fx_in[12];
            mag    <= fx_abs;
            exp    <= {{2{exp_in[5]}}, exp_in};
            sticky <= 1'b0;
            state  <= NORM;
          end
        end
        NORM: begin
          if (mag_zero) begin
            state <= ROUND;
          end else if (|mag[13:11]) begin
            mag    <= {1'b0, mag[13:-3]};
            exp    <= exp + 8'sd1;
            sticky <= sticky | mag[-4];
          end else if (!mag[10]) begin
            mag <= {mag[12:-4], 1'b0};
            exp <= exp - 8'sd1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          fp_out    <= fp_c;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_fx2fp.sv
// Scoreboard bench for cordic_fx2fp: directed vectors, latency and handshake checks.
module tb_cordic_fx2fp;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] fx_in;
  logic [5:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] fp_out;

  typedef struct {
    logic [15:0] fp;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_seen = 0;
  logic prev_valid = 1'b0;

  cordic_fx2fp dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fx_in     (fx_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_out    (fp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pop and compare on each rising out_valid.
  always @(negedge clk) begin
    if (!rst && out_valid && !prev_valid) begin
      n_seen++;
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %0h, expected none", fp_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("fp_out", 32'(fp_out), 32'(e.fp));
        check("latency_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_valid <= out_valid;
  end

  // Present one operand; out_valid is expected k+2 edges after the accept edge.
  task automatic send(input logic [16:0] fx, input logic [5:0] ex,
                      input logic [15:0] fp, input int k, input bit track);
    int t;
    @(negedge clk);
    fx_in    = fx;
    exp_in   = ex;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1");
    end else if (track) begin
      q.push_back('{fp: fp, cyc: cyc + 3 + k});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || !in_ready) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0 || !in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got pending=%0d, expected 0", q.size());
    end
  endtask

  localparam int NV = 18;
  logic [16:0] v_fx [NV] = '{17'h04000, 17'h1C000, 17'h08000, 17'h00010, 17'h00000,
                             17'h04008, 17'h04018, 17'h07FF8, 17'h04000, 17'h04000,
                             17'h10000, 17'h10000, 17'h04000, 17'h00001, 17'h1FFFF,
                             17'h0C011, 17'h0C010, 17'h04000};
  logic [5:0]  v_ex [NV] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                             6'h00, 6'h00, 6'h00, 6'h10, 6'h31,
                             6'h00, 6'h0E, 6'h32, 6'h00, 6'h00,
                             6'h00, 6'h00, 6'h0F};
  // -4.0 is 16'hC400; -4.0 * 2^14 overflows to -inf
  logic [15:0] v_fp [NV] = '{16'h3C00, 16'hBC00, 16'h4000, 16'h1400, 16'h0000,
                             16'h3C00, 16'h3C02, 16'h4000, 16'h7C00, 16'h0000,
                             16'hC400, 16'hFC00, 16'h0400, 16'h0400, 16'h8400,
                             16'h4201, 16'h4200, 16'h7800};
  int          v_k  [NV] = '{0, 0, 1, 10, 0, 0, 0, 0, 0, 0, 2, 2, 0, 14, 14, 1, 1, 0};

  initial begin
    int t;
    int seen_before;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    fx_in     = '0;
    exp_in    = '0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_fp_out", 32'(fp_out), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) send(v_fx[i], v_ex[i], v_fp[i], v_k[i], 1'b1);
    drain();

    // Back-pressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    send(17'h08000, 6'h00, 16'h4000, 1, 1'b1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_fp_out", 32'(fp_out), 32'h4000);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_after_out", 32'(in_ready), 32'd1);
    drain();

    // Reset mid-NORM discards the operation.
    seen_before = n_seen;
    send(17'h00010, 6'h00, 16'h1400, 10, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fp_out", 32'(fp_out), 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_no_output", 32'(n_seen), 32'(seen_before));

    // Post-reset operation still works.
    send(17'h04018, 6'h00, 16'h3C02, 0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
